block_out_fifo: RTL and testbench
=================================

BLOCK_OUT_FIFO -- requirements
Module: block_out_fifo

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 64: width in bits of one packed block from the combiner stage; a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO depth in blocks; a power of two, at least 2.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2: fill level at which almost_full asserts.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, BLOCK_SIZE bits: packed block, with the first bit of the stream at bit BLOCK_SIZE-1.
REQ-007 SHALL have port in_valid, input, 1 bit: push strobe; there is no backpressure to the writer.
REQ-008 SHALL have port in_last, input, 1 bit: marks the final block of an image.
REQ-009 SHALL have port in_keep, input, BLOCK_SIZE/8 bits: valid-byte mask, MSB-aligned; all ones unless in_last is set.
REQ-010 SHALL have ports m_axis_tdata (BLOCK_SIZE), m_axis_tkeep (BLOCK_SIZE/8), m_axis_tlast (1) and m_axis_tvalid (1) as outputs, and m_axis_tready (1) as an input, forming an AXI4-Stream master.
REQ-011 SHALL have port fill_level, output, $clog2(DEPTH)+1 bits: number of blocks currently held.
REQ-012 SHALL have port almost_full, output, 1 bit: asserted when fill_level >= AFULL_LEVEL.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag indicating a block was dropped.

Function
REQ-014 SHALL store {in_data, in_keep, in_last} as one entry in circular storage of DEPTH entries, using read/write pointers with a wrap bit.
REQ-015 SHALL be first-word-fall-through: a push into an empty FIFO at edge N SHALL give m_axis_tvalid=1 with that entry after edge N, i.e. one cycle of latency.
REQ-016 SHALL treat a beat as transferred only on a cycle with m_axis_tvalid & m_axis_tready; the read pointer SHALL advance only on such a cycle.
REQ-017 SHALL hold m_axis_tdata, m_axis_tkeep and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 SHALL, when full, accept a push only if a transfer occurs in the same cycle; fill_level then stays at DEPTH.
REQ-019 SHALL, on a push when full with no transfer, drop the block, leave the pointers unchanged and set overflow, which stays set until rst.
REQ-020 SHALL keep fill_level unchanged on a simultaneous push and transfer when not full.
REQ-021 SHALL, on a simultaneous push and transfer when fill_level=1, present the new entry on the following cycle with no bubble.
REQ-022 SHALL compute fill_level and almost_full from registered pointers, so both are valid one cycle after the edge that changed them.
REQ-023 SHALL drive m_axis_tvalid=0 whenever fill_level=0.
REQ-024 SHALL wrap the pointers modulo DEPTH; full is pointer equality with the wrap bits differing.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, clear both pointers, overflow, fill_level, almost_full and m_axis_tvalid, and drive m_axis_tlast=0.
REQ-026 SHALL, when rst is asserted mid-operation, discard all stored blocks, including a beat stalled by tready; in_valid SHALL be ignored while rst=1.
REQ-027 SHALL leave storage contents uninitialised; only the control state is reset.

Configuration
REQ-028 SHALL recognise the macro BLOCK_OUT_FIFO_BYTESWAP_EN.
REQ-029 SHALL, when BLOCK_OUT_FIFO_BYTESWAP_EN is defined, byte-reverse the output so in_data byte k (bits BLOCK_SIZE-1-8k down to BLOCK_SIZE-8-8k) appears on m_axis_tdata[8k+7:8k], with tkeep bit-reversed to match (little-endian AXI order).
REQ-030 SHALL, when BLOCK_OUT_FIFO_BYTESWAP_EN is undefined, pass tdata and tkeep through unchanged; all other behaviour SHALL be identical in both builds.

Verification (DEPTH=4, AFULL_LEVEL=3, BLOCK_SIZE=64)
REQ-031 SHALL cover single push 64'h0123456789ABCDEF with tready=1 -> tvalid one cycle later with that data (byteswap build: 64'hEFCDAB8967452301), tkeep=8'hFF, tlast=0, then fill_level returns to 0.
REQ-032 SHALL cover five pushes 1..5 with tready=0 -> almost_full=1 after the third, fill_level=4, overflow=1, and after tready=1 the output is 1,2,3,4 then tvalid=0 (block 5 dropped).
REQ-033 SHALL cover a full FIFO with tready=1 and a push every cycle for 10 cycles -> no overflow, fill_level stays 4, output order preserved.
REQ-034 SHALL cover a final block with in_last=1 and in_keep=8'hE0 -> tlast=1 and tkeep=8'hE0 (byteswap build: 8'h07) on that beat only.
REQ-035 SHALL cover rst=1 for one cycle with 3 blocks held and tready=0 -> next cycle tvalid=0, fill_level=0, overflow=0, and a subsequent push emerges correctly.
REQ-036 SHALL cover tready toggling 1,0,1,0 with 4 queued blocks -> each beat held stable while stalled and no duplicated or lost beats.

Source files
------------

// File: rtl/block_out_fifo.sv
// Output FIFO between the block combiner and an AXI4-Stream sink: first-word-fall-through,
// drop-on-full with a sticky overflow flag. Define BLOCK_OUT_FIFO_BYTESWAP_EN for little-endian byte order on the output.
module block_out_fifo #(
  parameter int BLOCK_SIZE  = 64,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BLOCK_SIZE-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [BLOCK_SIZE/8-1:0]   in_keep,
  output logic [BLOCK_SIZE-1:0]     m_axis_tdata,
  output logic [BLOCK_SIZE/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      almost_full,
  output logic                      overflow
);

  localparam int KW = BLOCK_SIZE / 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_CNT = AFULL_LEVEL[AW:0];

  typedef struct packed {
    logic [BLOCK_SIZE-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
  } entry_t;

  entry_t      mem_q [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        empty, full, pop, wr_en;

  // Full is the same slot with opposite wrap bits; empty is identical pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = m_axis_tvalid & m_axis_tready;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign wr_en = in_valid & ~rst & (~full | pop);

  // NOTE: combinational blocks use blocking '=' and assign every output first,
  // so no latch is inferred; clocked blocks below use non-blocking '<=' only.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d = overflow_q | (in_valid & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{data: in_data, keep: in_keep, last: in_last};
    end
  end

  // The head slot is never overwritten while it is unread, so outputs stay stable under stall.
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tvalid = ~empty;
  assign m_axis_tlast  = m_axis_tvalid & head.last;
  assign fill_level    = wr_ptr_q - rd_ptr_q;
  assign almost_full   = (fill_level >= AFULL_CNT);
  assign overflow      = overflow_q;

`ifdef BLOCK_OUT_FIFO_BYTESWAP_EN
  // Stream byte 0 sits at the MSB of the block; AXI wants it on lane 0.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    for (int k = 0; k < KW; k++) begin
      m_axis_tdata[8*k +: 8] = head.data[BLOCK_SIZE-8-8*k +: 8];
      m_axis_tkeep[k]        = head.keep[KW-1-k];
    end
  end
`else
  assign m_axis_tdata = head.data;
  assign m_axis_tkeep = head.keep;
`endif

endmodule

// File: tb/tb_block_out_fifo.sv
// Directed bench for block_out_fifo (DEPTH=4, AFULL_LEVEL=3, BLOCK_SIZE=64) with a
// reference model and expected-beat queue; honours BLOCK_OUT_FIFO_BYTESWAP_EN.
module tb_block_out_fifo;

  localparam int BS    = 64;
  localparam int KW    = BS / 8;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  typedef struct packed {
    logic [BS-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [BS-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic [KW-1:0] in_keep;
  logic [BS-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [2:0]    fill_level;
  logic          almost_full;
  logic          overflow;

  beat_t sb[$];
  int    cnt;
  logic  ovf;
  int    tests;
  int    fails;

  block_out_fifo #(.BLOCK_SIZE(BS), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_keep(in_keep),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .fill_level(fill_level), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [BS-1:0] exp_data(input logic [BS-1:0] d);
    logic [BS-1:0] r;
`ifdef BLOCK_OUT_FIFO_BYTESWAP_EN
    r = '0;
    for (int k = 0; k < KW; k++) r[8*k +: 8] = d[BS-8-8*k +: 8];
`else
    r = d;
`endif
    return r;
  endfunction

  function automatic logic [KW-1:0] exp_keep(input logic [KW-1:0] kp);
    logic [KW-1:0] r;
`ifdef BLOCK_OUT_FIFO_BYTESWAP_EN
    r = '0;
    for (int k = 0; k < KW; k++) r[k] = kp[KW-1-k];
`else
    r = kp;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check the head against the model, advance the model, then check the status outputs.
  task automatic cycle();
    beat_t e;
    logic  xfer;
    logic  acc;
    check("tvalid", 64'(m_axis_tvalid), 64'(cnt != 0));
    if (cnt != 0) begin
      e = sb[0];
      check("tdata", m_axis_tdata, exp_data(e.data));
      check("tkeep", 64'(m_axis_tkeep), 64'(exp_keep(e.keep)));
      check("tlast", 64'(m_axis_tlast), 64'(e.last));
    end else begin
      check("tlast_idle", 64'(m_axis_tlast), 64'(0));
    end
    xfer = (cnt != 0) && m_axis_tready;
    acc  = in_valid && !rst && ((cnt < DEPTH) || xfer);
    if (xfer) void'(sb.pop_front());
    if (rst) begin
      cnt = 0;
      sb.delete();
      ovf = 1'b0;
    end else begin
      if (in_valid && (cnt == DEPTH) && !xfer) ovf = 1'b1;
      if (acc) sb.push_back('{data: in_data, keep: in_keep, last: in_last});
      cnt = cnt + int'(acc) - int'(xfer);
    end
    @(posedge clk);
    #1;
    check("fill_level", 64'(fill_level), 64'(cnt));
    check("almost_full", 64'(almost_full), 64'(cnt >= AFULL));
    check("overflow", 64'(overflow), 64'(ovf));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic push(input logic [BS-1:0] d, input logic [KW-1:0] kp, input logic l);
    in_data  = d;
    in_keep  = kp;
    in_last  = l;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cnt   = 0;
    ovf   = 1'b0;
    rst   = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '1;
    in_last  = 1'b0;
    m_axis_tready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_fill", 64'(fill_level), 64'(0));
    check("rst_afull", 64'(almost_full), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));

    // Single push, drains on the next cycle.
    m_axis_tready = 1'b1;
    push(64'h0123456789ABCDEF, 8'hFF, 1'b0);
    check("single_visible", m_axis_tdata, exp_data(64'h0123456789ABCDEF));
    idle(2);

    // Five pushes into a stalled sink: block 5 dropped, overflow sticks.
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 5; i++) push(64'(i), 8'hFF, 1'b0);
    m_axis_tready = 1'b1;
    idle(6);
    check("overflow_sticky", 64'(overflow), 64'(1));

    // Full FIFO with continuous push and pop: no overflow, level holds at DEPTH.
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(64'h100 + 64'(i), 8'hFF, 1'b0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) push(64'h200 + 64'(i), 8'hFF, 1'b0);
    check("full_stream_fill", 64'(fill_level), 64'(DEPTH));
    idle(DEPTH + 2);

    // Final block with partial keep, streamed back-to-back through a one-deep level.
    push(64'hA1A2A3A4A5A6A7A8, 8'hFF, 1'b0);
    push(64'hB1B2B3B4B5B6B7B8, 8'hE0, 1'b1);
    check("last_tkeep", 64'(m_axis_tkeep), 64'(exp_keep(8'hE0)));
    check("last_tlast", 64'(m_axis_tlast), 64'(1));
    idle(2);

    // tready toggling with four queued blocks.
    m_axis_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(64'hC0 + 64'(i), 8'hFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      m_axis_tready = (i % 2 == 0);
      cycle();
    end

    // Reset mid-operation with a stalled beat and a push presented during reset.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) push(64'hD0 + 64'(i), 8'hFF, 1'b0);
    in_data  = 64'hDEADBEEFDEADBEEF;
    in_valid = 1'b1;
    do_reset();
    in_valid = 1'b0;
    check("post_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("post_rst_fill", 64'(fill_level), 64'(0));
    m_axis_tready = 1'b1;
    push(64'hFEDCBA9876543210, 8'hFF, 1'b0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
